// File: rtl/de4_led_pkg.sv
// Shared constants for the DE4 LED PWM/blink driver.
package de4_led_pkg;

    // Avalon-MM slave word addresses
    localparam logic [1:0] ADDR_DUTY       = 2'd0;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
    localparam logic [1:0] ADDR_BLINK_HALF = 2'd2;
    localparam logic [1:0] ADDR_STATUS     = 2'd3;

    // Duty value meaning "always on"
    localparam logic [7:0] DUTY_FULL = 8'hFF;

    localparam int unsigned PWM_BITS = 8;

endpackage

// File: rtl/de4_led_pwm_timebase.sv
// PWM timebase: prescaler, 256-tick PWM counter and period-aligned duty shadow.
module de4_led_pwm_timebase
    import de4_led_pkg::*;
#(
    parameter int unsigned PRESCALE = 195
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_tick,
    output logic                o_period_end,
    output logic                o_pwm_on,
    output logic [PWM_BITS-1:0] o_pwm_cnt
);

    localparam logic [15:0]         PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    logic [15:0]         r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_sh;
    logic                w_tick;
    logic                w_period_end;

    assign w_tick       = (r_pre_cnt == PRE_MAX);
    assign w_period_end = w_tick && (r_pwm_cnt == PWM_MAX);

    // Prescaler: counts 0..PRESCALE-1 and wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    // PWM counter: advances once per tick, wraps naturally at 255
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Duty shadow: only changes at period boundaries so no period is ever split;
    // a DUTY write in the boundary cycle is seen here one period later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty_sh <= DUTY_FULL;
        end else if (w_period_end) begin
            r_duty_sh <= i_duty;
        end
    end

    assign o_tick       = w_tick;
    assign o_period_end = w_period_end;
    assign o_pwm_cnt    = r_pwm_cnt;
    assign o_pwm_on     = (r_duty_sh == DUTY_FULL) || (r_pwm_cnt < r_duty_sh);

endmodule

// File: rtl/de4_led_pwm_driver.sv
// LED pin driver behind the LED PIO: global PWM dimming plus per-LED blinking,
// configured through a zero-wait Avalon-MM slave.
module de4_led_pwm_driver
    import de4_led_pkg::*;
#(
    parameter int unsigned PRESCALE    = 195,
    parameter int unsigned BLINK_RESET = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  led_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led_out
);

    logic [7:0]  r_duty;
    logic [7:0]  r_blink_mask;
    logic [15:0] r_blink_half;
    logic [15:0] r_blink_cnt;
    logic        r_blink_phase;
    logic [7:0]  r_led_out;

    logic        w_wr;
    logic        w_wr_half;
    logic        w_tick;
    logic        w_period_end;
    logic        w_pwm_on;
    logic [7:0]  w_pwm_cnt;
    logic        w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_wr_half = w_wr && (address == ADDR_BLINK_HALF);

    // Only the stored bits of writedata matter; the tick is not needed here
    assign w_unused = ^{writedata[31:16], w_tick};

    de4_led_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk          (clk),
        .reset        (reset),
        .i_duty       (r_duty),
        .o_tick       (w_tick),
        .o_period_end (w_period_end),
        .o_pwm_on     (w_pwm_on),
        .o_pwm_cnt    (w_pwm_cnt)
    );

    // Avalon register writes; STATUS is read-only so addr 3 falls through
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty       <= DUTY_FULL;
            r_blink_mask <= 8'h00;
            r_blink_half <= 16'(BLINK_RESET);
        end else if (w_wr) begin
            case (address)
                ADDR_DUTY:       r_duty       <= writedata[7:0];
                ADDR_BLINK_MASK: r_blink_mask <= writedata[7:0];
                ADDR_BLINK_HALF: r_blink_half <= writedata[15:0];
                default:         ;
            endcase
        end
    end

    // Blink timer: counts PWM periods, toggles phase every BLINK_HALF periods;
    // a BLINK_HALF write restarts it lit, and BLINK_HALF=0 parks it lit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wr_half || (r_blink_half == 16'd0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_period_end) begin
            if (r_blink_cnt == r_blink_half - 16'd1) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= !r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    // Registered pin drive: no combinational path from the PIO to the pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_out <= 8'h00;
        end else begin
            r_led_out <= led_in & {8{w_pwm_on}} & (~r_blink_mask | {8{r_blink_phase}});
        end
    end

    // Zero-wait read mux, independent of chipselect
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DUTY:       readdata = {24'd0, r_duty};
            ADDR_BLINK_MASK: readdata = {24'd0, r_blink_mask};
            ADDR_BLINK_HALF: readdata = {16'd0, r_blink_half};
            ADDR_STATUS:     readdata = {16'd0, w_pwm_cnt, 7'd0, r_blink_phase};
            default:         readdata = 32'd0;
        endcase
    end

    assign led_out = r_led_out;

endmodule

// File: tb/tb_de4_led_pwm_driver.sv
// Bench for de4_led_pwm_driver: two instances (PRESCALE 1 and 2) on shared stimulus,
// checked every cycle against a time-based behavioural model, plus literal checks.
module tb_de4_led_pwm_driver;

    localparam int P0 = 1;
    localparam int P1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd [2];
    logic [7:0]  led_o [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    de4_led_pwm_driver #(.PRESCALE(P0), .BLINK_RESET(250)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd[0]),
        .led_out    (led_o[0])
    );

    de4_led_pwm_driver #(.PRESCALE(P1), .BLINK_RESET(250)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd[1]),
        .led_out    (led_o[1])
    );

    // Model: t = cycles since reset, k = PWM periods since the blink last restarted.
    longint     m_t [2];
    longint     m_k [2];
    logic [7:0]  m_duty [2];
    logic [7:0]  m_mask [2];
    logic [15:0] m_half [2];
    logic [7:0]  m_duty_sh [2];
    logic [7:0]  m_led [2];
    bit          m_valid = 1'b0;

    function automatic longint pre_of(input int d);
        return (d == 0) ? longint'(P0) : longint'(P1);
    endfunction

    function automatic logic [7:0] m_pwm(input int d);
        return 8'((m_t[d] / pre_of(d)) % 256);
    endfunction

    function automatic logic m_phase(input int d);
        if (m_half[d] == 16'd0) return 1'b1;
        return ((m_k[d] / longint'(m_half[d])) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_duty[d]};
            2'd1:    return {24'd0, m_mask[d]};
            2'd2:    return {16'd0, m_half[d]};
            default: return {16'd0, m_pwm(d), 7'd0, m_phase(d)};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_t[d] = 0; m_k[d] = 0;
                m_duty[d] = 8'hFF; m_mask[d] = 8'h00; m_half[d] = 16'd250;
                m_duty_sh[d] = 8'hFF; m_led[d] = 8'h00;
            end else begin
                longint per = 256 * pre_of(d);
                logic   pe  = (m_t[d] % per) == per - 1;
                logic   on  = (m_duty_sh[d] == 8'hFF) || (m_pwm(d) < m_duty_sh[d]);
                logic   ph  = m_phase(d);
                m_led[d] = led_in & {8{on}} & (~m_mask[d] | {8{ph}});
                m_t[d]++;
                if (pe) begin
                    m_duty_sh[d] = m_duty[d];
                    m_k[d]++;
                end
                if (chipselect && !write_n) begin
                    case (address)
                        2'd0: m_duty[d] = writedata[7:0];
                        2'd1: m_mask[d] = writedata[7:0];
                        2'd2: begin m_half[d] = writedata[15:0]; m_k[d] = 0; end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            if (reset) m_valid = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("cmp_led0", 32'(led_o[0]), 32'(m_led[0]));
                check("cmp_led1", 32'(led_o[1]), 32'(m_led[1]));
                check("cmp_rd0", rd[0], m_read(0, address));
                check("cmp_rd1", rd[1], m_read(1, address));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = data;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Count highs of dut0 led_out[b] over n consecutive cycles
    task automatic count_bit(input int b, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (led_o[0][b]) cnt++;
        end
    endtask

    // Advance until the next dut0 edge has t%256 == target (bounded)
    task automatic align0(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if ((m_t[0] % 256) == longint'(target)) found = 1'b1;
            else step();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL align0: t%%256=%0d never reached, wanted %0d", m_t[0] % 256, target);
        end
    endtask

    initial begin
        int cnt;
        bit found;
        reset = 1'b1; led_in = 8'hA5; address = 2'd3;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

        // Reset held: pins dark, STATUS = phase 1, pwm 0
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("rst_led0", 32'(led_o[0]), 32'h0);
            check("rst_led1", 32'(led_o[1]), 32'h0);
        end
        check("rst_status0", rd[0], 32'h0000_0001);
        check("rst_status1", rd[1], 32'h0000_0001);
        step();
        reset = 1'b0; address = 2'd0;
        step();
        @(negedge clk);
        check("rd_duty_rst", rd[1], 32'h0000_00FF);
        address = 2'd1;
        step();
        @(negedge clk);
        check("led_a5_edge2", 32'(led_o[1]), 32'h0000_00A5);
        check("rd_mask_rst", rd[1], 32'h0);
        address = 2'd2;
        step();
        @(negedge clk);
        check("rd_half_rst", rd[0], 32'd250);

        // PWM duty 64 then 0
        led_in = 8'h01;
        wr(2'd0, 32'hFFFF_FF40);
        repeat (300) step();
        count_bit(0, 256, cnt);
        check("duty64_count", 32'(cnt), 32'd64);
        wr(2'd0, 32'd0);
        repeat (300) step();
        count_bit(0, 256, cnt);
        check("duty0_count", 32'(cnt), 32'd0);

        // DUTY write exactly on the period_end edge
        wr(2'd0, 32'd200);
        repeat (300) step();
        align0(255);
        wr(2'd0, 32'd16);
        count_bit(0, 256, cnt);
        check("boundary_old", 32'(cnt), 32'd200);
        count_bit(0, 256, cnt);
        check("boundary_new", 32'(cnt), 32'd16);

        // Blink: half = 2 periods, low nibble blinks, high nibble steady
        led_in = 8'hFF;
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'h0F);
        wr(2'd2, 32'd2);
        repeat (1100) step();
        count_bit(0, 1024, cnt);
        check("blink_low_half", 32'(cnt), 32'd512);
        count_bit(4, 1024, cnt);
        check("blink_high_on", 32'(cnt), 32'd1024);
        wr(2'd2, 32'd0);
        step();
        count_bit(0, 600, cnt);
        check("blink_off_steady", 32'(cnt), 32'd600);

        // Writes to STATUS change nothing
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd1;
        step();
        @(negedge clk);
        check("ro_mask", rd[0], 32'h0000_000F);
        address = 2'd0;
        step();
        @(negedge clk);
        check("ro_duty", rd[0], 32'h0000_00FF);

        // Reset while phase=0 and pwm_cnt=100
        wr(2'd2, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_pwm(0) == 8'd100 && !m_phase(0)) found = 1'b1;
            else step();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL align_blink: phase0/pwm100 not reached, got pwm %0d", m_pwm(0));
        end
        reset = 1'b1; address = 2'd3;
        step();
        @(negedge clk);
        check("midrst_status", rd[0], 32'h0000_0001);
        check("midrst_led", 32'(led_o[0]), 32'h0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("midrst_status_p0", rd[0], 32'h0000_0101);
        check("midrst_status_p1", rd[1], 32'h0000_0001);
        address = 2'd2;
        step();
        @(negedge clk);
        check("midrst_half", rd[0], 32'd250);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 20000; i++) begin
            led_in     = 8'($urandom);
            reset      = ($urandom_range(0, 4999) == 0);
            chipselect = ($urandom_range(0, 7) == 0);
            write_n    = ($urandom_range(0, 7) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            if (address == 2'd2 && $urandom_range(0, 7) < 6) writedata[15:0] = 16'($urandom_range(0, 3));
            step();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        step();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
